// File: rtl/debug_pkg.sv
// -----------------------------------------------------------------------------
// debug_pkg
// Shared definitions for the MCU debug controller: host command codes, the
// controller state encoding, the registered MCU request strobe bundle and a
// few small helpers used by the controller FSM.
//
// Optional feature macro used by the controller: DBG_TIMEOUT_EN (busy-wait
// watchdog). Nothing in this package depends on it.
// -----------------------------------------------------------------------------
package debug_pkg;

    typedef enum logic [3:0] {
        CMD_NONE        = 4'h0,
        CMD_PAUSE       = 4'h1,
        CMD_RESUME      = 4'h2,
        CMD_STEP        = 4'h3,
        CMD_RESET       = 4'h4,
        CMD_STATUS      = 4'h5,
        CMD_MEM_RD_BYTE = 4'h6,
        CMD_MEM_RD_WORD = 4'h7,
        CMD_REG_RD      = 4'h8,
        CMD_BP_ADD      = 4'h9,
        CMD_BP_RM       = 4'hA,
        CMD_MEM_WR_BYTE = 4'hB,
        CMD_MEM_WR_WORD = 4'hC,
        CMD_REG_WR      = 4'hD,
        CMD_BP_CLEAR    = 4'hE,
        CMD_RSVD        = 4'hF
    } cmd_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_PAUSE,
        S_WAIT_RESUME,
        S_WAIT_STEP,
        S_WAIT_MEM,
        S_WAIT_REG,
        S_WAIT_RESET,
        S_BREAK_HIT
    } state_e;

    // One bit per MCU request line; at most one is set at any time.
    typedef struct packed {
        logic pause;
        logic resume;
        logic mcu_reset;
        logic rf_rd;
        logic rf_wr;
        logic mem_rd;
        logic mem_wr;
    } req_t;

    localparam req_t REQ_NONE = '0;

    // States in which the controller waits on mcu_busy.
    function automatic logic is_wait_state(input state_e s);
        return (s == S_WAIT_PAUSE)  || (s == S_WAIT_RESUME) ||
               (s == S_WAIT_STEP)   || (s == S_WAIT_MEM)    ||
               (s == S_WAIT_REG)    || (s == S_WAIT_RESET);
    endfunction

    // Word accesses enable all lanes; byte accesses enable the addressed lane.
    function automatic logic [3:0] mem_byte_enable(input cmd_e c, input logic [1:0] ofs);
        if ((c == CMD_MEM_RD_WORD) || (c == CMD_MEM_WR_WORD))
            return 4'b1111;
        return 4'b0001 << ofs;
    endfunction

    function automatic logic is_mem_write(input cmd_e c);
        return (c == CMD_MEM_WR_BYTE) || (c == CMD_MEM_WR_WORD);
    endfunction

endpackage

// File: rtl/debug_controller_bp_table.sv
// -----------------------------------------------------------------------------
// bp_table
// Breakpoint table: NUM_BP slots, each a valid bit plus an address.
//
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset (clears valids)
//   add        write addr into the lowest free slot (no-op if already present
//              or if the table is full)
//   rm         invalidate every slot holding addr
//   clear      invalidate all slots
//   addr       address for add/rm and for the present lookup
//   pc         program counter compared against all valid slots
//   hit        pc matches a valid slot (combinational)
//   full       every slot is valid
//   present    addr matches a valid slot (combinational)
// -----------------------------------------------------------------------------
module bp_table
    import debug_pkg::*;
#(
    parameter int NUM_BP = 8,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              add,
    input  logic              rm,
    input  logic              clear,
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] pc,
    output logic              hit,
    output logic              full,
    output logic              present
);

    logic [NUM_BP-1:0] valid;
    logic [ADDR_W-1:0] slot_addr [NUM_BP];
    logic [NUM_BP-1:0] pc_match;
    logic [NUM_BP-1:0] addr_match;
    logic [NUM_BP-1:0] free_onehot;
    logic              do_add;

    always_comb begin
        pc_match   = '0;
        addr_match = '0;
        for (int i = 0; i < NUM_BP; i++) begin
            pc_match[i]   = valid[i] && (slot_addr[i] == pc);
            addr_match[i] = valid[i] && (slot_addr[i] == addr);
        end
    end

    // Lowest clear bit of valid; all zeros when the table is full because the
    // increment wraps.
    assign free_onehot = (valid + NUM_BP'(1)) & ~valid;

    assign hit     = |pc_match;
    assign full    = &valid;
    assign present = |addr_match;
    assign do_add  = add && !present && !full;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (clear) begin
            valid <= '0;
        end else if (rm) begin
            valid <= valid & ~addr_match;
        end else if (do_add) begin
            valid <= valid | free_onehot;
        end
    end

    // Addresses carry no reset; a slot's content is meaningful only while its
    // valid bit is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_BP; i++) begin
            if (do_add && free_onehot[i])
                slot_addr[i] <= addr;
        end
    end

endmodule

// File: rtl/debug_controller.sv
// -----------------------------------------------------------------------------
// debug_controller
// Host-side debug controller for a small MCU. Accepts one 4-bit command at a
// time, drives registered request strobes towards the MCU and waits on
// mcu_busy, tracks the paused state, and manages a breakpoint table that can
// stop the running MCU when pc reaches a programmed address.
//
// Build option: define DBG_TIMEOUT_EN to add a watchdog that abandons a wait
// after TIMEOUT_CYCLES busy cycles (err pulse, back to idle). Without it the
// controller waits on mcu_busy indefinitely and has no counter.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   cmd, addr, in_valid      host command, its address, command present
//   pc, mcu_busy             MCU program counter, MCU acknowledging/executing
//   pause, resume, mcu_reset MCU run-control request strobes
//   rf_rd, rf_wr             register file access strobes
//   mem_rd, mem_wr, mem_be   memory access strobes and byte enables
//   out_valid                a request strobe is being presented
//   ctrlr_busy               controller is not idle (commands not accepted)
//   mcu_paused               MCU is known to be paused
//   bp_hit                   one-cycle pulse on a breakpoint hit
//   bp_full                  every breakpoint slot is in use
//   err                      one-cycle pulse on a rejected command or timeout
// -----------------------------------------------------------------------------
module debug_controller
    import debug_pkg::*;
#(
    parameter int NUM_BP         = 8,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        cmd,
    input  logic [ADDR_W-1:0] addr,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] pc,
    input  logic              mcu_busy,
    output logic              pause,
    output logic              resume,
    output logic              mcu_reset,
    output logic              out_valid,
    output logic              rf_rd,
    output logic              rf_wr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [3:0]        mem_be,
    output logic              ctrlr_busy,
    output logic              mcu_paused,
    output logic              bp_hit,
    output logic              bp_full,
    output logic              err
);

    state_e            state;
    req_t              req;
    cmd_e              cmd_c;
    logic              last_hit_vld;
    logic [ADDR_W-1:0] last_hit;
    logic              table_hit;
    logic              table_present;
    logic              hit_now;
    logic              accept;
    logic              timeout;

    assign cmd_c = cmd_e'(cmd);

    assign pause     = req.pause;
    assign resume    = req.resume;
    assign mcu_reset = req.mcu_reset;
    assign rf_rd     = req.rf_rd;
    assign rf_wr     = req.rf_wr;
    assign mem_rd    = req.mem_rd;
    assign mem_wr    = req.mem_wr;

    // A hit needs a running MCU and a pc that is not the one we last stopped
    // on, so resuming from a breakpoint does not immediately stop again.
    assign hit_now = table_hit && !mcu_paused &&
                     ((state == S_IDLE) || (state == S_WAIT_RESUME)) &&
                     !(last_hit_vld && (pc == last_hit));

    // A breakpoint hit takes priority; the colliding command is dropped.
    assign accept = (state == S_IDLE) && in_valid && !hit_now;

    bp_table #(
        .NUM_BP (NUM_BP),
        .ADDR_W (ADDR_W)
    ) u_bp_table (
        .clk     (clk),
        .rst     (rst),
        .add     (accept && (cmd_c == CMD_BP_ADD)),
        .rm      (accept && (cmd_c == CMD_BP_RM)),
        .clear   (accept && (cmd_c == CMD_BP_CLEAR)),
        .addr    (addr),
        .pc      (pc),
        .hit     (table_hit),
        .full    (bp_full),
        .present (table_present)
    );

`ifdef DBG_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt;

    assign timeout = is_wait_state(state) && mcu_busy &&
                     (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Outside the wait states the counter sits at zero, so every entry from
    // idle starts fresh; the step-to-pause hand-over restarts it explicitly.
    always_ff @(posedge clk) begin
        if (rst || !is_wait_state(state) || ((state == S_WAIT_STEP) && !mcu_busy)) begin
            tmo_cnt <= '0;
        end else if (mcu_busy) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end
`else
    // No watchdog: waits end only when mcu_busy falls. The limit parameter
    // is kept so both builds share one parameter list.
    localparam bit TIMEOUT_LIMIT_SET = (TIMEOUT_CYCLES > 0);

    assign timeout = 1'b0 & TIMEOUT_LIMIT_SET;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            req          <= REQ_NONE;
            out_valid    <= 1'b0;
            mem_be       <= 4'b0000;
            ctrlr_busy   <= 1'b0;
            mcu_paused   <= 1'b0;
            bp_hit       <= 1'b0;
            err          <= 1'b0;
            last_hit_vld <= 1'b0;
        end else begin
            err    <= 1'b0;
            bp_hit <= 1'b0;

            if (hit_now) begin
                last_hit     <= pc;
                last_hit_vld <= 1'b1;
            end else if (last_hit_vld && (pc != last_hit)) begin
                last_hit_vld <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (hit_now) begin
                        bp_hit     <= 1'b1;
                        ctrlr_busy <= 1'b1;
                        state      <= S_BREAK_HIT;
                    end else if (accept) begin
                        case (cmd_c)
                            CMD_PAUSE: begin
                                req        <= '{pause: 1'b1, default: 1'b0};
                                out_valid  <= 1'b1;
                                ctrlr_busy <= 1'b1;
                                state      <= S_WAIT_PAUSE;
                            end
                            CMD_RESUME: begin
                                req        <= '{resume: 1'b1, default: 1'b0};
                                out_valid  <= 1'b1;
                                ctrlr_busy <= 1'b1;
                                state      <= S_WAIT_RESUME;
                            end
                            CMD_STEP: begin
                                if (mcu_paused) begin
                                    req        <= '{resume: 1'b1, default: 1'b0};
                                    out_valid  <= 1'b1;
                                    ctrlr_busy <= 1'b1;
                                    state      <= S_WAIT_STEP;
                                end else begin
                                    err <= 1'b1;
                                end
                            end
                            CMD_RESET: begin
                                req        <= '{mcu_reset: 1'b1, default: 1'b0};
                                out_valid  <= 1'b1;
                                ctrlr_busy <= 1'b1;
                                state      <= S_WAIT_RESET;
                            end
                            CMD_MEM_RD_BYTE, CMD_MEM_RD_WORD,
                            CMD_MEM_WR_BYTE, CMD_MEM_WR_WORD: begin
                                // Kind and lanes are latched here so the wait
                                // no longer depends on cmd/addr.
                                req        <= '{mem_rd: !is_mem_write(cmd_c),
                                                mem_wr: is_mem_write(cmd_c),
                                                default: 1'b0};
                                mem_be     <= mem_byte_enable(cmd_c, addr[1:0]);
                                out_valid  <= 1'b1;
                                ctrlr_busy <= 1'b1;
                                state      <= S_WAIT_MEM;
                            end
                            CMD_REG_RD: begin
                                req        <= '{rf_rd: 1'b1, default: 1'b0};
                                out_valid  <= 1'b1;
                                ctrlr_busy <= 1'b1;
                                state      <= S_WAIT_REG;
                            end
                            CMD_REG_WR: begin
                                req        <= '{rf_wr: 1'b1, default: 1'b0};
                                out_valid  <= 1'b1;
                                ctrlr_busy <= 1'b1;
                                state      <= S_WAIT_REG;
                            end
                            CMD_BP_ADD: begin
                                // A new address with no free slot is refused.
                                if (bp_full && !table_present)
                                    err <= 1'b1;
                            end
                            CMD_RSVD: begin
                                err <= 1'b1;
                            end
                            default: begin
                                // none, status, bp-rm and bp-clear-all finish
                                // here; table updates happen in bp_table.
                            end
                        endcase
                    end
                end

                S_WAIT_PAUSE, S_WAIT_RESUME, S_WAIT_MEM, S_WAIT_REG, S_WAIT_RESET: begin
                    if ((state == S_WAIT_RESUME) && hit_now) begin
                        req       <= REQ_NONE;
                        out_valid <= 1'b0;
                        bp_hit    <= 1'b1;
                        state     <= S_BREAK_HIT;
                    end else if (!mcu_busy) begin
                        req        <= REQ_NONE;
                        out_valid  <= 1'b0;
                        mem_be     <= 4'b0000;
                        ctrlr_busy <= 1'b0;
                        state      <= S_IDLE;
                        if (state == S_WAIT_PAUSE)
                            mcu_paused <= 1'b1;
                        else if ((state == S_WAIT_RESUME) || (state == S_WAIT_RESET))
                            mcu_paused <= 1'b0;
                    end else if (timeout) begin
                        req        <= REQ_NONE;
                        out_valid  <= 1'b0;
                        mem_be     <= 4'b0000;
                        ctrlr_busy <= 1'b0;
                        err        <= 1'b1;
                        state      <= S_IDLE;
                    end
                end

                S_WAIT_STEP: begin
                    // The single step ends by re-pausing the MCU.
                    if (!mcu_busy) begin
                        req   <= '{pause: 1'b1, default: 1'b0};
                        state <= S_WAIT_PAUSE;
                    end else if (timeout) begin
                        req        <= REQ_NONE;
                        out_valid  <= 1'b0;
                        ctrlr_busy <= 1'b0;
                        err        <= 1'b1;
                        state      <= S_IDLE;
                    end
                end

                S_BREAK_HIT: begin
                    req       <= '{pause: 1'b1, default: 1'b0};
                    out_valid <= 1'b1;
                    state     <= S_WAIT_PAUSE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_controller.sv
module tb_debug_controller;

    localparam int ADDR_W = 32;
    localparam int NUM_BP = 2;
    localparam int TMO    = 16;

    // Event vector: {out_valid, pause, resume, mcu_reset, rf_rd, rf_wr,
    //                mem_rd, mem_wr, mem_be[3:0], err, bp_hit}
    localparam logic [13:0] E_PAUSE  = 14'h3000;
    localparam logic [13:0] E_RESUME = 14'h2800;
    localparam logic [13:0] E_MRST   = 14'h2400;
    localparam logic [13:0] E_RFR    = 14'h2200;
    localparam logic [13:0] E_RFW    = 14'h2100;
    localparam logic [13:0] E_MR     = 14'h2080;
    localparam logic [13:0] E_MW     = 14'h2040;
    localparam logic [13:0] E_ERR    = 14'h0002;
    localparam logic [13:0] E_HIT    = 14'h0001;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [3:0]        cmd = 4'h0;
    logic [ADDR_W-1:0] addr = '0;
    logic              in_valid = 1'b0;
    logic [ADDR_W-1:0] pc = '0;
    logic              mcu_busy = 1'b0;
    logic pause, resume, mcu_reset, out_valid, rf_rd, rf_wr, mem_rd, mem_wr;
    logic [3:0] mem_be;
    logic ctrlr_busy, mcu_paused, bp_hit, bp_full, err;

    int n_checks = 0;
    int n_errors = 0;
    logic [13:0] expq[$];
    logic [13:0] dut_vec;
    logic [13:0] mon_prev = '0;
    logic [13:0] mon_exp;
    int          pause_cnt;

    always #5 clk = ~clk;

    debug_controller #(
        .NUM_BP         (NUM_BP),
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (cmd),
        .addr       (addr),
        .in_valid   (in_valid),
        .pc         (pc),
        .mcu_busy   (mcu_busy),
        .pause      (pause),
        .resume     (resume),
        .mcu_reset  (mcu_reset),
        .out_valid  (out_valid),
        .rf_rd      (rf_rd),
        .rf_wr      (rf_wr),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_be     (mem_be),
        .ctrlr_busy (ctrlr_busy),
        .mcu_paused (mcu_paused),
        .bp_hit     (bp_hit),
        .bp_full    (bp_full),
        .err        (err)
    );

    assign dut_vec = {out_valid, pause, resume, mcu_reset, rf_rd, rf_wr,
                      mem_rd, mem_wr, mem_be, err, bp_hit};

    function automatic logic [13:0] mem_ev(input logic rd, input logic [3:0] be);
        return (rd ? E_MR : E_MW) | {8'h00, be, 2'b00};
    endfunction

    // Monitor: every new non-idle output pattern is one event to score.
    initial begin
        forever begin
            @(negedge clk);
            if (dut_vec != 14'h0 && dut_vec != mon_prev) begin
                n_checks++;
                if (expq.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_event: got %h, expected none", dut_vec);
                end else begin
                    mon_exp = expq.pop_front();
                    if (dut_vec !== mon_exp) begin
                        n_errors++;
                        $display("FAIL event: got %h, expected %h", dut_vec, mon_exp);
                    end
                end
            end
            mon_prev = dut_vec;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] c, input logic [31:0] a);
        cmd      = c;
        addr     = a;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cmd      = 4'h0;
        addr     = '0;
    endtask

    // Hold mcu_busy for n cycles, then let the wait complete.
    task automatic busy_for(input int n);
        if (n > 0) mcu_busy = 1'b1;
        repeat (n) tick();
        mcu_busy = 1'b0;
        tick();
    endtask

    task automatic do_req(input logic [3:0] c, input logic [31:0] a,
                          input logic [13:0] ev, input int n);
        expq.push_back(ev);
        send(c, a);
        busy_for(n);
        tick();
    endtask

    initial begin
        // Reset
        repeat (3) tick();
        check("reset_outputs", dut_vec, 14'h0);
        check("reset_paused", mcu_paused, 1'b0);
        check("reset_busy", ctrlr_busy, 1'b0);
        check("reset_full", bp_full, 1'b0);
        rst = 1'b0;
        tick();

        // Pause with mcu_busy high for 3 cycles: pause stays up 4 cycles
        expq.push_back(E_PAUSE);
        send(4'h1, 0);
        pause_cnt = 0;
        if (pause) pause_cnt++;
        check("pause_busy_flag", ctrlr_busy, 1'b1);
        mcu_busy = 1'b1;
        repeat (3) begin
            tick();
            if (pause) pause_cnt++;
        end
        mcu_busy = 1'b0;
        tick();
        if (pause) pause_cnt++;
        check("pause_width", pause_cnt, 4);
        check("pause_paused", mcu_paused, 1'b1);
        check("pause_idle", ctrlr_busy, 1'b0);
        tick();

        do_req(4'h2, 0, E_RESUME, 1);
        check("resume_paused", mcu_paused, 1'b0);

        // Step while running is rejected
        expq.push_back(E_ERR);
        send(4'h3, 0);
        check("step_run_err", err, 1'b1);
        check("step_run_idle", ctrlr_busy, 1'b0);
        tick();

        // Pause, then step: resume followed by pause
        do_req(4'h1, 0, E_PAUSE, 0);
        expq.push_back(E_RESUME);
        expq.push_back(E_PAUSE);
        send(4'h3, 0);
        check("step_resume", resume, 1'b1);
        busy_for(2);
        check("step_pause", pause, 1'b1);
        tick();
        check("step_paused", mcu_paused, 1'b1);
        check("step_idle", ctrlr_busy, 1'b0);
        tick();
        do_req(4'h2, 0, E_RESUME, 0);

        // Byte read at offset 3; lanes held after cmd returns to 0
        expq.push_back(mem_ev(1'b1, 4'b1000));
        send(4'h6, 32'h0000_1003);
        mcu_busy = 1'b1;
        tick();
        check("memrd_be_hold", mem_be, 4'b1000);
        check("memrd_strobe", mem_rd, 1'b1);
        tick();
        mcu_busy = 1'b0;
        tick();
        tick();
        do_req(4'h7, 32'h10, mem_ev(1'b1, 4'b1111), 1);
        do_req(4'hB, 32'h21, mem_ev(1'b0, 4'b0010), 0);
        do_req(4'hC, 32'h22, mem_ev(1'b0, 4'b1111), 0);
        do_req(4'h8, 0, E_RFR, 1);
        do_req(4'hD, 0, E_RFW, 0);

        // MCU reset clears the paused flag
        do_req(4'h1, 0, E_PAUSE, 0);
        do_req(4'h4, 0, E_MRST, 2);
        check("reset_cmd_paused", mcu_paused, 1'b0);

        // Reserved command and status
        expq.push_back(E_ERR);
        send(4'hF, 0);
        check("rsvd_idle", ctrlr_busy, 1'b0);
        tick();
        send(4'h5, 0);
        check("status_idle", ctrlr_busy, 1'b0);
        tick();

        // Breakpoint table, NUM_BP = 2
        send(4'h9, 32'h100);
        check("bp_add_idle", ctrlr_busy, 1'b0);
        send(4'h9, 32'h100);
        check("bp_dup_not_full", bp_full, 1'b0);
        send(4'h9, 32'h200);
        check("bp_two_full", bp_full, 1'b1);
        expq.push_back(E_ERR);
        send(4'h9, 32'h300);
        check("bp_full_err", err, 1'b1);
        tick();
        send(4'hA, 32'h300);
        check("bp_rm_miss", bp_full, 1'b1);
        send(4'hA, 32'h200);
        check("bp_rm_hit", bp_full, 1'b0);
        send(4'h9, 32'h300);
        check("bp_refill", bp_full, 1'b1);
        send(4'hE, 0);
        check("bp_clear", bp_full, 1'b0);
        tick();

        // Breakpoint hit and no re-hit on the same pc
        send(4'h9, 32'h100);
        expq.push_back(E_HIT);
        expq.push_back(E_PAUSE);
        pc = 32'h100;
        tick();
        check("hit_pulse", bp_hit, 1'b1);
        check("hit_no_pause_yet", pause, 1'b0);
        tick();
        check("hit_pause", pause, 1'b1);
        check("hit_pulse_end", bp_hit, 1'b0);
        tick();
        check("hit_paused", mcu_paused, 1'b1);
        do_req(4'h2, 0, E_RESUME, 0);
        repeat (3) begin
            tick();
            check("no_rehit", bp_hit, 1'b0);
        end
        pc = 32'h104;
        tick();
        // Hit again, colliding with a reserved command that must be dropped
        expq.push_back(E_HIT);
        expq.push_back(E_PAUSE);
        pc = 32'h100;
        send(4'hF, 0);
        check("rehit_pulse", bp_hit, 1'b1);
        check("rehit_priority", err, 1'b0);
        tick();
        tick();
        check("rehit_paused", mcu_paused, 1'b1);
        do_req(4'h2, 0, E_RESUME, 0);
        pc = 32'h0;
        send(4'hE, 0);
        tick();

`ifdef DBG_TIMEOUT_EN
        expq.push_back(E_RFR);
        expq.push_back(E_ERR);
        send(4'h8, 0);
        mcu_busy = 1'b1;
        repeat (15) tick();
        check("tmo_still_wait", ctrlr_busy, 1'b1);
        check("tmo_strobe", rf_rd, 1'b1);
        tick();
        check("tmo_err", err, 1'b1);
        check("tmo_idle", ctrlr_busy, 1'b0);
        check("tmo_drop", rf_rd, 1'b0);
        check("tmo_paused", mcu_paused, 1'b0);
        mcu_busy = 1'b0;
        tick();
`else
        expq.push_back(E_RFR);
        send(4'h8, 0);
        mcu_busy = 1'b1;
        repeat (20) tick();
        check("wait_forever_busy", ctrlr_busy, 1'b1);
        check("wait_forever_strobe", rf_rd, 1'b1);
        mcu_busy = 1'b0;
        tick();
        tick();
`endif

        // Reset in the middle of a wait
        do_req(4'h1, 0, E_PAUSE, 0);
        send(4'h9, 32'h500);
        send(4'h9, 32'h600);
        expq.push_back(E_RFR);
        send(4'h8, 0);
        mcu_busy = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("rst_mid_outputs", dut_vec, 14'h0);
        check("rst_mid_paused", mcu_paused, 1'b0);
        check("rst_mid_busy", ctrlr_busy, 1'b0);
        check("rst_mid_full", bp_full, 1'b0);
        rst = 1'b0;
        mcu_busy = 1'b0;
        tick();

        for (int i = 0; i < 20 && expq.size() != 0; i++) tick();
        check("queue_drained", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
